// File: rtl/packet_trigger_gen.sv
// Packet qualifier and trigger-window generator for the backscatter modulator.
// Optional early end of the trigger window on envelope loss: PACKET_TRIGGER_EARLY_STOP_EN.
module packet_trigger_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 16,
  parameter int START_DELAY = 320,
  parameter int TRIG_LEN    = 3200,
  parameter int HOLDOFF     = 1600,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envelope_in,
  input  logic       enable,
  output logic       trigger_signal,
  output logic       busy,
  output logic [7:0] packet_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_QUALIFY = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_ACTIVE  = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] START_C    = CNT_W'(START_DELAY);
  localparam logic [CNT_W-1:0] TRIG_C     = CNT_W'(TRIG_LEN);
  localparam logic [CNT_W-1:0] HOLD_C     = CNT_W'(HOLDOFF);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   env_s;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   seen_low_q, seen_low_d;
  logic                   trig_q, busy_q;
  logic [7:0]             pcount_q;
  logic                   early_stop;

  assign env_s = sync_q[SYNC_STAGES-1];

`ifdef PACKET_TRIGGER_EARLY_STOP_EN
  logic [CNT_W-1:0] low_q, low_d;

  // Run length of consecutive low samples while the window is open
  always_comb begin
    low_d      = '0;
    early_stop = 1'b0;
    if (state_q == ST_ACTIVE && !env_s) begin
      low_d      = low_q + ONE_C;
      early_stop = (low_q == MIN_HIGH_C - ONE_C);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) low_q <= '0;
    else        low_q <= low_d;
  end
`else
  assign early_stop = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      seen_low_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (env_s) begin
            state_d = ST_QUALIFY;
            cnt_d   = ONE_C;
          end
        end
        ST_QUALIFY: begin
          if (!env_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == MIN_HIGH_C) begin
            state_d = ST_DELAY;
            cnt_d   = ONE_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        ST_DELAY: begin
          if (!env_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == START_C) begin
            state_d    = ST_ACTIVE;
            cnt_d      = ONE_C;
            seen_low_d = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        ST_ACTIVE: begin
          if (!env_s) seen_low_d = 1'b1;
          if (cnt_q == TRIG_C || early_stop) begin
            state_d = ST_HOLDOFF;
            cnt_d   = ONE_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        ST_HOLDOFF: begin
          if (!env_s) seen_low_d = 1'b1;
          // Saturate at the terminal count until the packet has ended
          if (cnt_q == HOLD_C) begin
            if (seen_low_q || !env_s) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q     <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      pcount_q   <= 8'd0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], envelope_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      trig_q     <= (state_d == ST_ACTIVE);
      busy_q     <= (state_d != ST_IDLE);
      if (state_d == ST_ACTIVE && state_q != ST_ACTIVE) pcount_q <= pcount_q + 8'd1;
    end
  end

  assign trigger_signal = trig_q;
  assign busy           = busy_q;
  assign packet_count   = pcount_q;

endmodule

// File: tb/tb_packet_trigger_gen.sv
// Directed bench for packet_trigger_gen: expected trigger pulses are queued
// when a packet is driven and checked when the trigger edges appear.
module tb_packet_trigger_gen;

  localparam int SYNC  = 2;
  localparam int MINH  = 4;
  localparam int DLY   = 10;
  localparam int TLEN  = 20;
  localparam int HOLD  = 8;
  // Rise edge counted from the edge the new envelope level is driven after
  localparam int LAT   = SYNC + MINH + DLY + 1;

  typedef struct {
    int         rise;
    int         len;
    logic [7:0] pc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       envelope_in = 1'b0;
  logic       enable = 1'b0;
  logic       trigger_signal;
  logic       busy;
  logic [7:0] packet_count;

  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  exp_t       exp_q[$];
  exp_t       mon_item;
  logic [7:0] exp_pc = 8'd0;
  logic       trig_prev = 1'b0;
  int         rise_edge_q = 0;
  int         len_q = 0;

  packet_trigger_gen #(
    .SYNC_STAGES(SYNC),
    .MIN_HIGH   (MINH),
    .START_DELAY(DLY),
    .TRIG_LEN   (TLEN),
    .HOLDOFF    (HOLD),
    .CNT_W      (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .envelope_in   (envelope_in),
    .enable        (enable),
    .trigger_signal(trigger_signal),
    .busy          (busy),
    .packet_count  (packet_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_pkt(input int len);
    exp_t e;
    exp_pc = exp_pc + 8'd1;
    e.rise = edge_cnt + LAT;
    e.len  = len;
    e.pc   = exp_pc;
    exp_q.push_back(e);
    $display("push: rise at edge %0d, len %0d, packet_count %0d", e.rise, e.len, e.pc);
  endtask

  task automatic packet(input int high_n, input int low_n);
    envelope_in = 1'b1;
    step(high_n);
    envelope_in = 1'b0;
    step(low_n);
  endtask

  // Scoreboard side: pop on each trigger rise, check width on each fall
  always @(negedge clock) begin
    if (trigger_signal === 1'b1 && !trig_prev) begin
      chk("expected_rise", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_item = exp_q.pop_front();
        chk("rise_edge", edge_cnt, mon_item.rise);
        chk("rise_packet_count", 32'(packet_count), 32'(mon_item.pc));
        $display("rise: edge %0d packet_count %0d", edge_cnt, packet_count);
        rise_edge_q <= edge_cnt;
        len_q       <= mon_item.len;
      end
    end
    if (trigger_signal !== 1'b1 && trig_prev) begin
      chk("trigger_len", edge_cnt - rise_edge_q, len_q);
      $display("fall: edge %0d width %0d", edge_cnt, edge_cnt - rise_edge_q);
    end
    trig_prev <= (trigger_signal === 1'b1);
  end

  initial begin
    // Reset state
    step(3);
    chk("reset_trigger", 32'(trigger_signal), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(packet_count), 32'd0);
    reset = 1'b1;
    step(2);

    // Nominal packet; the long envelope must not retrigger
    enable = 1'b1;
    push_pkt(TLEN);
    packet(100, 20);
    chk("nominal_queue", exp_q.size(), 0);
    chk("nominal_count", 32'(packet_count), 32'(exp_pc));
    chk("nominal_busy", 32'(busy), 32'd0);

    // Glitch rejection: short pulses only flash busy
    for (int i = 0; i < 5; i++) begin
      envelope_in = 1'b1;
      step(3);
      chk("glitch_busy_hi", 32'(busy), 32'd1);
      envelope_in = 1'b0;
      step(3);
      chk("glitch_busy_lo", 32'(busy), 32'd0);
      step(4);
    end
    chk("glitch_count", 32'(packet_count), 32'(exp_pc));

    // Abort during the start delay
    envelope_in = 1'b1;
    step(8);
    chk("abort_busy_hi", 32'(busy), 32'd1);
    envelope_in = 1'b0;
    step(3);
    chk("abort_busy_lo", 32'(busy), 32'd0);
    chk("abort_count", 32'(packet_count), 32'(exp_pc));
    step(5);

    // Re-arm with two packets
    push_pkt(TLEN);
    packet(100, 20);
    push_pkt(TLEN);
    packet(100, 20);
    chk("rearm_queue", exp_q.size(), 0);
    chk("rearm_count", 32'(packet_count), 32'(exp_pc));

    // Enable dropped in trigger cycle 5
    push_pkt(5);
    envelope_in = 1'b1;
    step(LAT + 4);
    enable = 1'b0;
    step(1);
    chk("en_drop_trigger", 32'(trigger_signal), 32'd0);
    chk("en_drop_busy", 32'(busy), 32'd0);
    chk("en_drop_count", 32'(packet_count), 32'(exp_pc));
    envelope_in = 1'b0;
    step(5);
    enable = 1'b1;
    step(3);

    // Reset asserted in trigger cycle 5
    push_pkt(5);
    envelope_in = 1'b1;
    step(LAT + 4);
    reset = 1'b0;
    step(1);
    chk("rst_trigger", 32'(trigger_signal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(packet_count), 32'd0);
    exp_pc = 8'd0;
    reset = 1'b1;
    envelope_in = 1'b0;
    step(5);

    // 256 packets wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      push_pkt(TLEN);
      packet(40, 12);
    end
    chk("wrap_count", 32'(packet_count), 32'd0);
    chk("wrap_queue", exp_q.size(), 0);

    // Envelope lost in trigger cycle 6
`ifdef PACKET_TRIGGER_EARLY_STOP_EN
    push_pkt(MINH + SYNC + 5);
`else
    push_pkt(TLEN);
`endif
    envelope_in = 1'b1;
    step(LAT + 5);
    packet(0, 40);
    chk("early_count", 32'(packet_count), 32'(exp_pc));
    chk("final_queue", exp_q.size(), 0);
    chk("final_trigger", 32'(trigger_signal), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
